decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, datapath/immediate width.
REQ-002 SHALL have parameter ALU_CTRL_BITS, default 5, ALU control code width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, instr is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts instr this cycle.
REQ-007 SHALL have port instr, input, 32, RV64I instruction word.
REQ-008 SHALL have port out_valid, output, 1, decoded bundle is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the bundle.
REQ-010 SHALL have port alu_ctrl, output, ALU_CTRL_BITS, ALU operation code.
REQ-011 SHALL have port imm, output, REG_WIDTH, sign-extended immediate.
REQ-012 SHALL have ports rs1_addr, rs2_addr, rd_addr, output, 5 each, register indices.
REQ-013 SHALL have ports reg_write, mem_read, mem_write, branch, illegal, output, 1 each, control flags.
REQ-014 SHALL have port illegal_count, output, 16, count of illegal instructions accepted.

Function
REQ-015 SHALL hold a one-entry output register; in_ready = !out_valid || out_ready.
REQ-016 SHALL capture the decoded instr on in_valid && in_ready; out_valid rises the next cycle (latency 1).
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid after out_valid && out_ready with no simultaneous capture; simultaneous accept and capture replaces the bundle with no bubble.
REQ-019 SHALL encode alu_ctrl for OP (0110011): ADD 00000, SUB 00001, XOR 00010, OR 00011, AND 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001.
REQ-020 SHALL encode OP-IMM (0010011): ADDI 10000, XORI 10001, ORI 10010, ANDI 10011, SLLI 10100, SRLI 10101, SRAI 10110, SLTI 10111, SLTIU 11000.
REQ-021 SHALL decode LOAD (0000011) and STORE (0100011) as 10000 with I/S immediate; mem_read, mem_write set accordingly.
REQ-022 SHALL decode BRANCH (1100011): BEQ/BNE 00001, BLT/BGE 01000, BLTU/BGEU 01001; B immediate; branch=1.
REQ-023 SHALL take shifts' shamt from instr[25:20]; funct6 must be 000000 (SLLI/SRLI) or 010000 (SRAI), else illegal.
REQ-024 SHALL sign-extend all immediates from instr[31] to REG_WIDTH; rs2_addr=instr[24:20], rs1_addr=instr[19:15], rd_addr=instr[11:7] unconditionally.
REQ-025 SHALL set reg_write for OP, OP-IMM, LOAD only, forced 0 when rd_addr=0.
REQ-026 SHALL mark any other opcode/funct combination illegal: illegal=1, alu_ctrl=00000, all other flags 0.
REQ-027 SHALL increment illegal_count on each accepted illegal instr, saturating at 0xFFFF.

Reset
REQ-028 SHALL on rst clear out_valid, illegal_count, and all bundle registers to 0; an in-flight bundle is discarded.
REQ-029 SHALL hold in_ready=1 during and after rst (output register empty); rst overrides a simultaneous capture.

Structure
REQ-030 SHALL place ALU control codes, opcode values, and funct3/funct7 constants in shared package riscv_pkg, also used by the ALU.
REQ-031 SHALL use one combinational sub-module imm_gen (instr, format select -> REG_WIDTH immediate).

Verification
REQ-032 add x3,x1,x2 (0x002081B3) -> next cycle out_valid=1, alu_ctrl=00000, rs1=1, rs2=2, rd=3, reg_write=1.
REQ-033 addi x5,x0,-1 (0xFFF00293) -> alu_ctrl=10000, imm=0xFFFFFFFFFFFFFFFF, rd=5.
REQ-034 srai x6,x7,63 (0x43F3D313) -> alu_ctrl=10110, imm[5:0]=63, rs1=7.
REQ-035 sw x2,8(x1) (0x0020A423) -> alu_ctrl=10000, imm=8, mem_write=1, reg_write=0.
REQ-036 two back-to-back instrs, out_ready=0 for 3 cycles -> first bundle stable, in_ready=0, second delivered the cycle after out_ready=1.
REQ-037 instr 0x00000000 twice -> illegal=1, illegal_count=2; rst mid-stall -> out_valid=0, illegal_count=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I encodings: opcodes, funct fields, ALU control codes and decode types.
// Also imported by the ALU so both sides agree on the alu_ctrl encoding.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_SHIFT = 6'b000000;
    localparam logic [5:0] F6_SRA   = 6'b010000;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_XOR   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_SLT   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_ADDI  = 5'b10000;
    localparam logic [4:0] ALU_XORI  = 5'b10001;
    localparam logic [4:0] ALU_ORI   = 5'b10010;
    localparam logic [4:0] ALU_ANDI  = 5'b10011;
    localparam logic [4:0] ALU_SLLI  = 5'b10100;
    localparam logic [4:0] ALU_SRLI  = 5'b10101;
    localparam logic [4:0] ALU_SRAI  = 5'b10110;
    localparam logic [4:0] ALU_SLTI  = 5'b10111;
    localparam logic [4:0] ALU_SLTIU = 5'b11000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_SH   = 3'd4
    } imm_fmt_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ctrl_flags_t;

    // RV64I has no load with funct3=111 and no store with funct3[2]=1.
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return f3 != 3'b111;
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return f3[2] == 1'b0;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the I/S/B/shamt field layout and
// sign-extends from instr[31] up to REG_WIDTH.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 64
) (
    input  logic [31:0]          instr,
    input  imm_fmt_e             fmt,
    output logic [REG_WIDTH-1:0] imm
);

    logic [12:0] low13;
    logic        sign_bit;
    logic        unused_bits;

    assign unused_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        low13    = '0;
        sign_bit = 1'b0;
        case (fmt)
            IMM_I: begin
                low13    = {instr[31], instr[31:20]};
                sign_bit = instr[31];
            end
            IMM_S: begin
                low13    = {instr[31], instr[31:25], instr[11:7]};
                sign_bit = instr[31];
            end
            IMM_B: begin
                low13    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sign_bit = instr[31];
            end
            IMM_SH: begin
                // legal shifts always have instr[31]=0, so this is the plain shamt
                low13    = {{7{instr[31]}}, instr[25:20]};
                sign_bit = instr[31];
            end
            default: begin
                low13    = '0;
                sign_bit = 1'b0;
            end
        endcase
    end

    assign imm[12:0] = low13;

    genvar gi;
    generate
        for (gi = 13; gi < REG_WIDTH; gi++) begin : g_sext
            assign imm[gi] = sign_bit;
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage with a one-entry valid/ready output register and a
// saturating counter of accepted illegal instructions.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH     = 64,
    parameter int ALU_CTRL_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
    output logic [REG_WIDTH-1:0]     imm,
    output logic [4:0]               rs1_addr,
    output logic [4:0]               rs2_addr,
    output logic [4:0]               rd_addr,
    output logic                     reg_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     branch,
    output logic                     illegal,
    output logic [15:0]              illegal_count
);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [5:0]     funct6;
    logic [4:0]     dec_alu;
    imm_fmt_e       dec_fmt;
    ctrl_flags_t    dec_flags;
    logic           dec_legal;
    logic [REG_WIDTH-1:0] dec_imm;
    logic           accept;

    logic                     out_valid_q, out_valid_d;
    logic [ALU_CTRL_BITS-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [REG_WIDTH-1:0]     imm_q, imm_d;
    logic [4:0]               rs1_q, rs1_d;
    logic [4:0]               rs2_q, rs2_d;
    logic [4:0]               rd_q, rd_d;
    ctrl_flags_t              flags_q, flags_d;
    logic [15:0]              illegal_count_q, illegal_count_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct6 = instr[31:26];

    always_comb begin
        dec_alu   = ALU_ADD;
        dec_fmt   = IMM_NONE;
        dec_flags = '0;
        dec_legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_flags.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: dec_alu = ALU_ADD;
                        F3_SLL:     dec_alu = ALU_SLL;
                        F3_SLT:     dec_alu = ALU_SLT;
                        F3_SLTU:    dec_alu = ALU_SLTU;
                        F3_XOR:     dec_alu = ALU_XOR;
                        F3_SRL_SRA: dec_alu = ALU_SRL;
                        F3_OR:      dec_alu = ALU_OR;
                        default:    dec_alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    dec_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    dec_alu = ALU_SRA;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_flags.reg_write = 1'b1;
                dec_fmt = IMM_I;
                case (funct3)
                    F3_ADD_SUB: dec_alu = ALU_ADDI;
                    F3_SLT:     dec_alu = ALU_SLTI;
                    F3_SLTU:    dec_alu = ALU_SLTIU;
                    F3_XOR:     dec_alu = ALU_XORI;
                    F3_OR:      dec_alu = ALU_ORI;
                    F3_AND:     dec_alu = ALU_ANDI;
                    F3_SLL: begin
                        dec_fmt   = IMM_SH;
                        dec_alu   = ALU_SLLI;
                        dec_legal = (funct6 == F6_SHIFT);
                    end
                    default: begin
                        dec_fmt = IMM_SH;
                        if (funct6 == F6_SHIFT) begin
                            dec_alu = ALU_SRLI;
                        end else if (funct6 == F6_SRA) begin
                            dec_alu = ALU_SRAI;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_alu            = ALU_ADDI;
                dec_fmt            = IMM_I;
                dec_flags.reg_write = 1'b1;
                dec_flags.mem_read = 1'b1;
                dec_legal          = load_f3_ok(funct3);
            end
            OPC_STORE: begin
                dec_alu             = ALU_ADDI;
                dec_fmt             = IMM_S;
                dec_flags.mem_write = 1'b1;
                dec_legal           = store_f3_ok(funct3);
            end
            OPC_BRANCH: begin
                dec_fmt          = IMM_B;
                dec_flags.branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   dec_alu = ALU_SUB;
                    F3_BLT, F3_BGE:   dec_alu = ALU_SLT;
                    F3_BLTU, F3_BGEU: dec_alu = ALU_SLTU;
                    default:          dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase

        // an illegal word carries no operation: only the illegal flag survives
        if (!dec_legal) begin
            dec_alu           = ALU_ADD;
            dec_fmt           = IMM_NONE;
            dec_flags         = '0;
            dec_flags.illegal = 1'b1;
        end
        if (instr[11:7] == 5'd0) begin
            dec_flags.reg_write = 1'b0;
        end
    end

    imm_gen #(
        .REG_WIDTH(REG_WIDTH)
    ) u_imm_gen (
        .instr(instr),
        .fmt  (dec_fmt),
        .imm  (dec_imm)
    );

    // reset empties the register, so the stage is ready throughout reset
    assign in_ready = rst || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d     = out_valid_q;
        alu_ctrl_d      = alu_ctrl_q;
        imm_d           = imm_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        rd_d            = rd_q;
        flags_d         = flags_q;
        illegal_count_d = illegal_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            alu_ctrl_d  = ALU_CTRL_BITS'(dec_alu);
            imm_d       = dec_imm;
            rs1_d       = instr[19:15];
            rs2_d       = instr[24:20];
            rd_d        = instr[11:7];
            flags_d     = dec_flags;
            if (dec_flags.illegal && illegal_count_q != 16'hFFFF) begin
                illegal_count_d = illegal_count_q + 16'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            alu_ctrl_q      <= '0;
            imm_q           <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            flags_q         <= '0;
            illegal_count_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            alu_ctrl_q      <= alu_ctrl_d;
            imm_q           <= imm_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            rd_q            <= rd_d;
            flags_q         <= flags_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign imm           = imm_q;
    assign rs1_addr      = rs1_q;
    assign rs2_addr      = rs2_q;
    assign rd_addr       = rd_q;
    assign reg_write     = flags_q.reg_write;
    assign mem_read      = flags_q.mem_read;
    assign mem_write     = flags_q.mem_write;
    assign branch        = flags_q.branch;
    assign illegal       = flags_q.illegal;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: a mnemonic-level reference model
// predicts each accepted instruction; a monitor compares whatever the DUT presents.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_ctrl;
    logic [63:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_write, mem_read, mem_write, branch, illegal;
    logic [15:0] illegal_count;

    always #5 clk = ~clk;

    decode_stage #(.REG_WIDTH(64), .ALU_CTRL_BITS(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .illegal(illegal), .illegal_count(illegal_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [63:0] imm;
        logic        has_imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, br, ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         model_cnt = 0;
    bit         model_occ = 1'b0;
    bit         occ_pending = 1'b0;
    logic [4:0] alu_of[string];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction name per the RV64I base tables; empty string means illegal.
    function automatic string mnem(input logic [31:0] w);
        string m = "";
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [5:0] f6 = w[31:26];
        case (w[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: m = "add";  3'd1: m = "sll";  3'd2: m = "slt";  3'd3: m = "sltu";
                        3'd4: m = "xor";  3'd5: m = "srl";  3'd6: m = "or";   default: m = "and";
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
                else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
            end
            7'b0010011: begin
                case (f3)
                    3'd0: m = "addi"; 3'd2: m = "slti"; 3'd3: m = "sltiu";
                    3'd4: m = "xori"; 3'd6: m = "ori";  3'd7: m = "andi";
                    3'd1: m = (f6 == 6'd0) ? "slli" : "";
                    default: m = (f6 == 6'd0) ? "srli" : ((f6 == 6'b010000) ? "srai" : "");
                endcase
            end
            7'b0000011: m = (f3 != 3'd7) ? "load" : "";
            7'b0100011: m = (f3 < 3'd4) ? "store" : "";
            7'b1100011: begin
                case (f3)
                    3'd0: m = "beq";  3'd1: m = "bne";  3'd4: m = "blt";
                    3'd5: m = "bge";  3'd6: m = "bltu"; 3'd7: m = "bgeu";
                    default: m = "";
                endcase
            end
            default: m = "";
        endcase
        return m;
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t   e;
        string  m = mnem(w);
        longint b = 0;
        bit is_op = (w[6:0] == 7'b0110011);
        bit is_oi = (w[6:0] == 7'b0010011);
        bit is_ld = (w[6:0] == 7'b0000011);
        bit is_st = (w[6:0] == 7'b0100011);
        bit is_br = (w[6:0] == 7'b1100011);
        e.instr = w;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.ill = (m == "");
        e.alu = 5'd0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.has_imm = 0; e.cnt = 0;
        if (!e.ill) begin
            e.alu = alu_of[m];
            e.rw  = (is_op || is_oi || is_ld) && (w[11:7] != 5'd0);
            e.mr  = is_ld; e.mw = is_st; e.br = is_br;
            e.has_imm = !is_op;
            if (m == "slli" || m == "srli" || m == "srai")
                b = longint'(w[25:20]);
            else if (is_oi || is_ld)
                b = -2048 * longint'(w[31]) + longint'(w[30:20]);
            else if (is_st)
                b = -2048 * longint'(w[31]) + 32 * longint'(w[30:25]) + longint'(w[11:7]);
            else if (is_br)
                b = -4096 * longint'(w[31]) + 2048 * longint'(w[7]) + 32 * longint'(w[30:25])
                    + 2 * longint'(w[11:8]);
        end
        e.imm = 64'(b);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                w[6:0] = 7'b0110011;
                if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            1, 7: begin
                w[6:0] = 7'b0010011;
                if ($urandom_range(0, 2) != 0) w[31:26] = $urandom_range(0, 1) ? 6'b010000 : 6'b000000;
            end
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w = 32'h0;
            default: ;
        endcase
        return w;
    endfunction

    // One clock of stimulus: inputs change on the falling edge, and anything the
    // DUT will take on the next rising edge is pushed to the scoreboard.
    task automatic drive_cycle(input bit v, input logic [31:0] w, input bit rdy, input bit r);
        bit   acc;
        exp_t e;
        @(negedge clk);
        model_occ = occ_pending;
        rst = r; in_valid = v; instr = w; out_ready = rdy;
        if (r) begin
            sb.delete();
            model_cnt = 0;
        end
        #1;
        check("in_ready", in_ready, r || !model_occ || rdy);
        acc = v && !r && (!model_occ || rdy);
        if (acc) begin
            e = model(w);
            if (e.ill && model_cnt < 65535) model_cnt++;
            e.cnt = 16'(model_cnt);
            sb.push_back(e);
        end
        occ_pending = r ? 1'b0 : (acc ? 1'b1 : ((model_occ && rdy) ? 1'b0 : model_occ));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("out_valid", out_valid, model_occ);
                if (model_occ) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboard_empty: got out_valid=%0b expected a queued bundle", out_valid);
                    end else begin
                        e = sb[0];
                        check("alu_ctrl", alu_ctrl, e.alu);
                        if (e.has_imm) check("imm", imm, e.imm);
                        check("rs1_addr", rs1_addr, e.rs1);
                        check("rs2_addr", rs2_addr, e.rs2);
                        check("rd_addr", rd_addr, e.rd);
                        check("flags", {reg_write, mem_read, mem_write, branch, illegal},
                              {e.rw, e.mr, e.mw, e.br, e.ill});
                        check("illegal_count", illegal_count, e.cnt);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            $display("txn instr=%08h alu=%05b imm=%016h rd=%0d ill=%0b cnt=%0d",
                                     e.instr, alu_ctrl, imm, rd_addr, illegal, illegal_count);
                        end
                    end
                end
            end
        end
    end

    initial begin
        alu_of["add"] = 5'b00000;  alu_of["sub"] = 5'b00001;  alu_of["xor"] = 5'b00010;
        alu_of["or"]  = 5'b00011;  alu_of["and"] = 5'b00100;  alu_of["sll"] = 5'b00101;
        alu_of["srl"] = 5'b00110;  alu_of["sra"] = 5'b00111;  alu_of["slt"] = 5'b01000;
        alu_of["sltu"] = 5'b01001;
        alu_of["addi"] = 5'b10000; alu_of["xori"] = 5'b10001; alu_of["ori"] = 5'b10010;
        alu_of["andi"] = 5'b10011; alu_of["slli"] = 5'b10100; alu_of["srli"] = 5'b10101;
        alu_of["srai"] = 5'b10110; alu_of["slti"] = 5'b10111; alu_of["sltiu"] = 5'b11000;
        alu_of["load"] = 5'b10000; alu_of["store"] = 5'b10000;
        alu_of["beq"] = 5'b00001;  alu_of["bne"] = 5'b00001;  alu_of["blt"] = 5'b01000;
        alu_of["bge"] = 5'b01000;  alu_of["bltu"] = 5'b01001; alu_of["bgeu"] = 5'b01001;

        rst = 1'b1; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0;
        drive_cycle(1, 32'h002081B3, 0, 1);
        drive_cycle(0, 32'h0, 0, 1);
        drive_cycle(0, 32'h0, 1, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_illegal_count", illegal_count, 0);
        check("reset_bundle", {alu_ctrl, imm, rs1_addr, rs2_addr, rd_addr}, 0);
        check("reset_flags", {reg_write, mem_read, mem_write, branch, illegal}, 0);

        // directed examples, streamed back to back with downstream always ready
        drive_cycle(1, 32'h002081B3, 1, 0);
        drive_cycle(1, 32'hFFF00293, 1, 0);
        drive_cycle(1, 32'h43F3D313, 1, 0);
        drive_cycle(1, 32'h0020A423, 1, 0);
        drive_cycle(0, 32'h0, 1, 0);

        // stall: second instr is held off until the first is taken
        drive_cycle(1, 32'h40208033, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1, 32'hFE208EE3, 0, 0);
        drive_cycle(1, 32'hFE208EE3, 1, 0);
        drive_cycle(0, 32'h0, 1, 0);
        drive_cycle(0, 32'h0, 1, 0);

        for (int i = 0; i < 1500; i++)
            drive_cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 32'h0, 1, 0);

        // two illegal zero words, stall on the second, then reset mid-stall
        drive_cycle(0, 32'h0, 1, 1);
        drive_cycle(1, 32'h0, 1, 0);
        drive_cycle(1, 32'h0, 1, 0);
        drive_cycle(0, 32'h0, 0, 0);
        drive_cycle(0, 32'h0, 0, 0);
        check("illegal_count_two", illegal_count, 2);
        drive_cycle(1, 32'h002081B3, 0, 1);
        drive_cycle(0, 32'h0, 0, 0);
        check("rst_stall_out_valid", out_valid, 0);
        check("rst_stall_illegal_count", illegal_count, 0);

        for (int i = 0; i < 4; i++) drive_cycle(0, 32'h0, 1, 0);
        #5;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
